// File: rtl/rf_access_ctrl.sv
// Initiator side of the single-port register file: buffers writebacks in a FIFO,
// arbitrates the shared port between operand reads and writes, and forwards pending results.
module rf_access_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [ADDR_W-1:0]           rd_left_addr,
    input  logic [ADDR_W-1:0]           rd_right_addr,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_left,
    output logic [DATA_W-1:0]           rsp_right,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [ADDR_W-1:0]           wb_addr,
    input  logic [DATA_W-1:0]           wb_data,
    input  logic                        drain,
    output logic                        rf_we,
    output logic [ADDR_W-1:0]           rf_left_addr,
    output logic [ADDR_W-1:0]           rf_right_addr,
    output logic [ADDR_W-1:0]           rf_dest_addr,
    output logic [DATA_W-1:0]           rf_result,
    input  logic [DATA_W-1:0]           rf_left_out,
    input  logic [DATA_W-1:0]           rf_right_out,
    output logic [$clog2(WB_DEPTH):0]   pending,
    output logic                        idle
);

    localparam int unsigned PTR_W = $clog2(WB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

    logic [ADDR_W-1:0] fifo_addr [WB_DEPTH];
    logic [DATA_W-1:0] fifo_data [WB_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              empty;
    op_e               op;
    logic              push;
    logic              pop;
    logic              rd_accept;

    logic              rsp_valid_q;
    logic              fwd_left_hit_q;
    logic              fwd_right_hit_q;
    logic [DATA_W-1:0] fwd_left_q;
    logic [DATA_W-1:0] fwd_right_q;

    logic              fwd_left_hit;
    logic              fwd_right_hit;
    logic [DATA_W-1:0] fwd_left_data;
    logic [DATA_W-1:0] fwd_right_data;
    logic [PTR_W-1:0]  fwd_idx;

    assign full  = (count == CNT_W'(WB_DEPTH));
    assign empty = (count == CNT_W'(0));

    // Port arbitration; a drain with nothing buffered leaves the port quiet.
    always_comb begin
        op = OP_NONE;
        if (!rst_n) begin
            op = OP_NONE;
        end else if ((full || drain) && !empty) begin
            op = OP_WRITE;
        end else if (rd_valid && !drain) begin
            op = OP_READ;
        end else if (!empty) begin
            op = OP_WRITE;
        end
    end

    assign rd_ready  = !rst_n || (!full && !drain);
    assign wb_ready  = !rst_n || !full || (op == OP_WRITE);
    assign rd_accept = rst_n && rd_valid && rd_ready;
    assign push      = rst_n && wb_valid && wb_ready;
    assign pop       = (op == OP_WRITE);

    // Scan oldest to youngest so the youngest matching entry is the one kept.
    always_comb begin
        fwd_left_hit   = 1'b0;
        fwd_right_hit  = 1'b0;
        fwd_left_data  = '0;
        fwd_right_data = '0;
        fwd_idx        = rd_ptr;
        for (int unsigned k = 0; k < WB_DEPTH; k++) begin
            fwd_idx = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if (fifo_addr[fwd_idx] == rd_left_addr) begin
                    fwd_left_hit  = 1'b1;
                    fwd_left_data = fifo_data[fwd_idx];
                end
                if (fifo_addr[fwd_idx] == rd_right_addr) begin
                    fwd_right_hit  = 1'b1;
                    fwd_right_data = fifo_data[fwd_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            rsp_valid_q     <= 1'b0;
            fwd_left_hit_q  <= 1'b0;
            fwd_right_hit_q <= 1'b0;
            fwd_left_q      <= '0;
            fwd_right_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count + CNT_W'(push) - CNT_W'(pop);
            rsp_valid_q <= rd_accept;
            if (rd_accept) begin
                fwd_left_hit_q  <= fwd_left_hit;
                fwd_right_hit_q <= fwd_right_hit;
                fwd_left_q      <= fwd_left_data;
                fwd_right_q     <= fwd_right_data;
            end
        end
    end

    // Entry storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wb_addr;
            fifo_data[wr_ptr] <= wb_data;
        end
    end

    assign rf_we         = (op == OP_WRITE);
    assign rf_left_addr  = rd_left_addr;
    assign rf_right_addr = rd_right_addr;
    assign rf_dest_addr  = empty ? '0 : fifo_addr[rd_ptr];
    assign rf_result     = empty ? '0 : fifo_data[rd_ptr];

    assign rsp_valid = rsp_valid_q;
    assign rsp_left  = !rsp_valid_q ? '0 : (fwd_left_hit_q  ? fwd_left_q  : rf_left_out);
    assign rsp_right = !rsp_valid_q ? '0 : (fwd_right_hit_q ? fwd_right_q : rf_right_out);

    assign pending = count;
    assign idle    = !rst_n || (empty && !rsp_valid_q);

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural single-port register file model.
module tb_rf_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_left_addr;
    logic [4:0]  rd_right_addr;
    logic        rsp_valid;
    logic [31:0] rsp_left;
    logic [31:0] rsp_right;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        drain;
    logic        rf_we;
    logic [4:0]  rf_left_addr;
    logic [4:0]  rf_right_addr;
    logic [4:0]  rf_dest_addr;
    logic [31:0] rf_result;
    logic [31:0] rf_left_out;
    logic [31:0] rf_right_out;
    logic [2:0]  pending;
    logic        idle;

    logic [31:0] rf_mem [32];
    logic        init_mem;
    int          n_checks;
    int          n_errors;

    rf_access_ctrl #(.DATA_W(32), .ADDR_W(5), .WB_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_left_addr(rd_left_addr), .rd_right_addr(rd_right_addr),
        .rsp_valid(rsp_valid), .rsp_left(rsp_left), .rsp_right(rsp_right),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .drain(drain), .rf_we(rf_we),
        .rf_left_addr(rf_left_addr), .rf_right_addr(rf_right_addr),
        .rf_dest_addr(rf_dest_addr), .rf_result(rf_result),
        .rf_left_out(rf_left_out), .rf_right_out(rf_right_out),
        .pending(pending), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: register r holds 0xF000_00rr until written.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hF000_0000 | 32'(i);
        end else if (rf_we) begin
            rf_mem[rf_dest_addr] <= rf_result;
        end
        rf_left_out  <= rf_mem[rf_left_addr];
        rf_right_out <= rf_mem[rf_right_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_rd(input logic v, input logic [4:0] l, input logic [4:0] r);
        rd_valid      = v;
        rd_left_addr  = l;
        rd_right_addr = r;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        init_mem = 1'b1;
        rst_n    = 1'b0;
        drain    = 1'b0;
        set_rd(1'b0, 5'd0, 5'd0);
        set_wb(1'b0, 5'd0, 32'h0);

        // Reset held two clocks
        tick();
        tick();
        settle();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rf_we",     32'(rf_we),     32'd0);
        check("rst_pending",   32'(pending),   32'd0);
        check("rst_rd_ready",  32'(rd_ready),  32'd1);
        check("rst_wb_ready",  32'(wb_ready),  32'd1);
        check("rst_idle",      32'(idle),      32'd1);
        check("rst_rsp_left",  rsp_left,       32'd0);
        init_mem = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Single writeback, no reads
        set_wb(1'b1, 5'd3, 32'hA5A5_0003);
        settle();
        check("wb1_ready", 32'(wb_ready), 32'd1);
        check("wb1_we_before", 32'(rf_we), 32'd0);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        settle();
        check("wb1_pending1", 32'(pending),      32'd1);
        check("wb1_we",       32'(rf_we),        32'd1);
        check("wb1_dest",     32'(rf_dest_addr), 32'd3);
        check("wb1_result",   rf_result,         32'hA5A5_0003);
        tick();
        settle();
        check("wb1_pending0", 32'(pending), 32'd0);
        check("wb1_we_after", 32'(rf_we),   32'd0);
        check("wb1_idle",     32'(idle),    32'd1);

        // Forwarding: same-cycle push not forwarded, youngest entry wins
        set_rd(1'b1, 5'd1, 5'd2);
        set_wb(1'b1, 5'd7, 32'h11);
        tick();
        set_rd(1'b1, 5'd7, 5'd3);
        set_wb(1'b1, 5'd7, 32'h22);
        settle();
        check("fw_rspA_valid", 32'(rsp_valid), 32'd1);
        check("fw_rspA_left",  rsp_left,       32'hF000_0001);
        check("fw_rspA_right", rsp_right,      32'hF000_0002);
        tick();
        set_rd(1'b1, 5'd7, 5'd8);
        set_wb(1'b0, 5'd0, 32'h0);
        settle();
        check("fw_pending2",   32'(pending), 32'd2);
        check("fw_no_we",      32'(rf_we),   32'd0);
        check("fw_rspB_left",  rsp_left,     32'h11);
        check("fw_rspB_right", rsp_right,    32'hA5A5_0003);
        tick();
        set_rd(1'b0, 5'd0, 5'd0);
        settle();
        check("fw_rspC_left",  rsp_left,      32'h22);
        check("fw_rspC_right", rsp_right,     32'hF000_0008);
        check("fw_pop1_dest",  32'(rf_dest_addr), 32'd7);
        check("fw_pop1_res",   rf_result,     32'h11);
        tick();
        check("fw_pop2_res",   rf_result,     32'h22);
        tick();
        settle();
        check("fw_drained", 32'(pending), 32'd0);
        set_rd(1'b1, 5'd7, 5'd3);
        tick();
        set_rd(1'b0, 5'd0, 5'd0);
        settle();
        check("fw_rf_left",  rsp_left,  32'h22);
        check("fw_rf_right", rsp_right, 32'hA5A5_0003);
        tick();

        // Fill to full with reads held; push while full pops head
        for (int i = 0; i < 4; i++) begin
            set_rd(1'b1, 5'd0, 5'd0);
            set_wb(1'b1, 5'(10 + i), 32'h100 + 32'(i));
            tick();
        end
        set_wb(1'b1, 5'd14, 32'h104);
        settle();
        check("full_pending",  32'(pending),  32'd4);
        check("full_rd_ready", 32'(rd_ready), 32'd0);
        check("full_we",       32'(rf_we),    32'd1);
        check("full_wb_ready", 32'(wb_ready), 32'd1);
        check("full_dest",     32'(rf_dest_addr), 32'd10);
        check("full_result",   rf_result,     32'h100);
        tick();
        set_rd(1'b0, 5'd0, 5'd0);
        set_wb(1'b0, 5'd0, 32'h0);
        settle();
        check("full_pending_hold", 32'(pending),      32'd4);
        check("full_dest2",        32'(rf_dest_addr), 32'd11);
        for (int i = 0; i < 5; i++) tick();
        check("full_empty", 32'(pending), 32'd0);
        check("full_idle",  32'(idle),    32'd1);
        set_rd(1'b1, 5'd14, 5'd10);
        tick();
        set_rd(1'b0, 5'd0, 5'd0);
        settle();
        check("full_wrap_left",  rsp_left,  32'h104);
        check("full_wrap_right", rsp_right, 32'h100);
        tick();

        // Three buffered entries, then drain flushes them in order
        set_rd(1'b1, 5'd0, 5'd0);
        set_wb(1'b1, 5'd20, 32'h200);
        tick();
        set_wb(1'b1, 5'd21, 32'h201);
        tick();
        set_wb(1'b1, 5'd20, 32'h202);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        set_rd(1'b1, 5'd20, 5'd21);
        tick();
        drain = 1'b1;
        settle();
        check("dr_fwd_left",  rsp_left,  32'h202);
        check("dr_fwd_right", rsp_right, 32'h201);
        check("dr_pending3",  32'(pending), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("dr_rd_ready", 32'(rd_ready), 32'd0);
            check("dr_we",       32'(rf_we),    32'd1);
            check("dr_dest",     32'(rf_dest_addr), (i == 1) ? 32'd21 : 32'd20);
            check("dr_result",   rf_result,     32'h200 + 32'(i));
            tick();
        end
        check("dr_idle",         32'(idle),     32'd1);
        check("dr_pending0",     32'(pending),  32'd0);
        check("dr_rd_ready_end", 32'(rd_ready), 32'd0);
        drain = 1'b0;
        set_rd(1'b0, 5'd0, 5'd0);
        tick();

        // Reset with three entries buffered and a response in flight
        set_rd(1'b1, 5'd0, 5'd0);
        set_wb(1'b1, 5'd5, 32'h55);
        tick();
        set_wb(1'b1, 5'd6, 32'h66);
        tick();
        set_wb(1'b1, 5'd9, 32'h99);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        set_rd(1'b1, 5'd5, 5'd6);
        tick();
        set_rd(1'b0, 5'd0, 5'd0);
        settle();
        check("mr_pending3",  32'(pending),   32'd3);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("mr_rsp_left",  rsp_left,       32'h55);
        rst_n = 1'b0;
        settle();
        check("mr_in_rst_rd_ready", 32'(rd_ready), 32'd1);
        check("mr_in_rst_wb_ready", 32'(wb_ready), 32'd1);
        check("mr_in_rst_we",       32'(rf_we),    32'd0);
        check("mr_in_rst_idle",     32'(idle),     32'd1);
        tick();
        rst_n = 1'b1;
        settle();
        check("mr_pending0",   32'(pending),   32'd0);
        check("mr_rsp_valid0", 32'(rsp_valid), 32'd0);
        check("mr_rsp_left0",  rsp_left,       32'd0);
        check("mr_we0",        32'(rf_we),     32'd0);
        tick();
        check("mr_we_later", 32'(rf_we), 32'd0);
        set_rd(1'b1, 5'd5, 5'd9);
        tick();
        set_rd(1'b0, 5'd0, 5'd0);
        settle();
        check("mr_dropped_left",  rsp_left,  32'hF000_0005);
        check("mr_dropped_right", rsp_right, 32'hF000_0009);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
